// File: rtl/lock_pkg.sv
// Shared encodings for the password-lock sequencer: internal FSM states,
// the 2-bit externally visible state code and the LED patterns.
package lock_pkg;

  localparam int unsigned SEC_W = 8;

  typedef enum logic [2:0] {
    ST_WAITING  = 3'd0,
    ST_EDITING  = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_ALARMING = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    EXT_WAITING  = 2'b00,
    EXT_EDITING  = 2'b01,
    EXT_UNLOCKED = 2'b10,
    EXT_ALARMING = 2'b11
  } ext_state_e;

  localparam logic [3:0] LED_WAITING = 4'b0001;
  localparam logic [3:0] LED_EDITING = 4'b0011;
  localparam logic [3:0] LED_ON      = 4'b1111;

  // CHECK is reported as EDITING to the outside world
  function automatic ext_state_e to_ext(state_e s);
    case (s)
      ST_EDITING, ST_CHECK: return EXT_EDITING;
      ST_UNLOCKED:          return EXT_UNLOCKED;
      ST_ALARMING:          return EXT_ALARMING;
      default:              return EXT_WAITING;
    endcase
  endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Pulse/level bundle between the debounced front end, the password datapath
// and the lock sequencer.
interface lock_controller_if;
  logic       identity;
  logic       edit_toggle;
  logic       digit_loaded;
  logic       ok_pulse;
  logic       admin_clear;
  logic       check_valid;
  logic       check_match;
  logic [1:0] state_out;
  logic       check_req;
  logic       pswd_we;
  logic       clear_entry;
  logic [1:0] err_count;
  logic [3:0] leds;

  modport master (
    output identity, edit_toggle, digit_loaded, ok_pulse, admin_clear,
           check_valid, check_match,
    input  state_out, check_req, pswd_we, clear_entry, err_count, leds
  );

  modport slave (
    input  identity, edit_toggle, digit_loaded, ok_pulse, admin_clear,
           check_valid, check_match,
    output state_out, check_req, pswd_we, clear_entry, err_count, leds
  );
endinterface

// File: rtl/lock_timer.sv
// Free-running 1-s prescaler with a loadable seconds down-counter; load restarts
// the prescaler so a timeout lands exactly T*TICK_DIV cycles after the load edge.
module lock_timer import lock_pkg::*; #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEC_W-1:0] load_val,
  input  logic             freeze,
  output logic             sec_strobe,
  output logic             half_strobe,
  output logic             timeout
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST      = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] HALF_LAST = PW'(TICK_DIV / 2 - 1);

  logic [PW-1:0]    presc_q;
  logic [SEC_W-1:0] secs_q;

  assign sec_strobe  = !freeze && (presc_q == LAST);
  assign half_strobe = !freeze && (presc_q == HALF_LAST);
  assign timeout     = sec_strobe && (secs_q == SEC_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      secs_q  <= '0;
    end else if (load) begin
      presc_q <= '0;
      secs_q  <= load_val;
    end else if (!freeze) begin
      presc_q <= sec_strobe ? '0 : presc_q + 1'b1;
      if (sec_strobe && (secs_q != '0))
        secs_q <= secs_q - 1'b1;
    end
  end

endmodule

// File: rtl/lock_controller.sv
// Password-lock sequencer: WAITING/EDITING/CHECK/UNLOCKED/ALARMING FSM with
// edit/unlock timeouts, wrong-attempt counter and LED pattern; all outputs registered.
module lock_controller import lock_pkg::*; #(
  parameter int unsigned TICK_DIV         = 50_000_000,
  parameter int unsigned EDIT_TIMEOUT_S   = 10,
  parameter int unsigned UNLOCK_TIMEOUT_S = 20,
  parameter int unsigned MAX_ERRORS       = 3
) (
  input  logic              clk,
  input  logic              rst,
  lock_controller_if.slave  bus
);

  state_e           state_q, state_d;
  ext_state_e       state_out_q, state_out_d;
  logic [3:0]       leds_q, leds_d;
  logic [1:0]       err_q, err_d;
  logic             clr_q, clr_d, req_q, req_d, we_q, we_d;

  logic             tmr_load;
  logic [SEC_W-1:0] tmr_val;
  logic             tmr_freeze, sec_strobe, half_strobe, timeout;

  assign tmr_freeze = (state_q == ST_CHECK);

  lock_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .freeze     (tmr_freeze),
    .sec_strobe (sec_strobe),
    .half_strobe(half_strobe),
    .timeout    (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAITING;
      state_out_q <= EXT_WAITING;
      leds_q      <= LED_WAITING;
      err_q       <= '0;
      clr_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      state_out_q <= state_out_d;
      leds_q      <= leds_d;
      err_q       <= err_d;
      clr_q       <= clr_d;
      req_q       <= req_d;
      we_q        <= we_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    clr_d    = 1'b0;
    req_d    = 1'b0;
    we_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_WAITING: begin
        if (bus.edit_toggle) begin
          state_d  = ST_EDITING;
          clr_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = SEC_W'(EDIT_TIMEOUT_S);
        end
      end
      ST_EDITING: begin
        if (bus.ok_pulse) begin
          if (!bus.identity) begin
            state_d = ST_WAITING;
            we_d    = 1'b1;
            clr_d   = 1'b1;
          end else begin
            state_d = ST_CHECK;
            req_d   = 1'b1;
          end
        end else if (bus.digit_loaded) begin
          tmr_load = 1'b1;
          tmr_val  = SEC_W'(EDIT_TIMEOUT_S);
        end else if (timeout) begin
          state_d = ST_WAITING;
          clr_d   = 1'b1;
        end
      end
      ST_CHECK: begin
        if (bus.check_valid) begin
          if (bus.check_match) begin
            state_d  = ST_UNLOCKED;
            err_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = SEC_W'(UNLOCK_TIMEOUT_S);
          end else begin
            err_d = (err_q == 2'd3) ? 2'd3 : err_q + 2'd1;
            if (err_d == 2'(MAX_ERRORS)) begin
              // load of 0 only restarts the prescaler so the LED blink phase begins on entry
              state_d  = ST_ALARMING;
              tmr_load = 1'b1;
            end else begin
              state_d  = ST_EDITING;
              clr_d    = 1'b1;
              tmr_load = 1'b1;
              tmr_val  = SEC_W'(EDIT_TIMEOUT_S);
            end
          end
        end
      end
      ST_UNLOCKED: begin
        if (bus.ok_pulse || timeout) begin
          state_d = ST_WAITING;
          clr_d   = 1'b1;
        end
      end
      ST_ALARMING: begin
        if (bus.admin_clear) begin
          state_d = ST_WAITING;
          err_d   = '0;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_WAITING;
    endcase
    // park the seconds counter whenever the lock goes idle
    if (state_d == ST_WAITING && state_q != ST_WAITING) begin
      tmr_load = 1'b1;
      tmr_val  = '0;
    end
  end

  always_comb begin
    state_out_d = to_ext(state_d);
    leds_d      = LED_WAITING;
    case (state_d)
      ST_EDITING, ST_CHECK: leds_d = LED_EDITING;
      ST_UNLOCKED:          leds_d = LED_ON;
      ST_ALARMING: begin
        if (state_q != ST_ALARMING)
          leds_d = LED_ON;
        else if (half_strobe || sec_strobe)
          leds_d = ~leds_q;
        else
          leds_d = leds_q;
      end
      default:              leds_d = LED_WAITING;
    endcase
  end

  assign bus.state_out   = state_out_q;
  assign bus.leds        = leds_q;
  assign bus.err_count   = err_q;
  assign bus.clear_entry = clr_q;
  assign bus.check_req   = req_q;
  assign bus.pswd_we     = we_q;

endmodule

// File: tb/tb_lock_controller.sv
// Table-driven bench for lock_controller with a scoreboard queue, plus hand-written
// timeout, freeze and keep-alive sequences.
module tb_lock_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lock_controller_if bus();

  lock_controller #(
    .TICK_DIV(4), .EDIT_TIMEOUT_S(3), .UNLOCK_TIMEOUT_S(5), .MAX_ERRORS(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // stim bits: {rst, identity, edit, digit, ok, admin_clear, check_valid, check_match}
  // exp  bits: {state_out[1:0], check_req, pswd_we, clear_entry, err_count[1:0], leds[3:0]}
  typedef struct {
    string      nm;
    logic [7:0] stim;
    logic [10:0] exp;
  } vec_t;

  localparam logic [7:0] IDLE = 8'b0100_0000;

  vec_t        tbl[$];
  logic [10:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [10:0] E(logic [1:0] st, logic [2:0] p, logic [1:0] er, logic [3:0] ld);
    return {st, p, er, ld};
  endfunction

  function automatic vec_t V(string nm, logic [7:0] s, logic [1:0] st, logic [2:0] p,
                             logic [1:0] er, logic [3:0] ld);
    vec_t v;
    v.nm = nm; v.stim = s; v.exp = E(st, p, er, ld);
    return v;
  endfunction

  task automatic drive(input logic [7:0] s);
    {rst, bus.identity, bus.edit_toggle, bus.digit_loaded, bus.ok_pulse,
     bus.admin_clear, bus.check_valid, bus.check_match} = s;
  endtask

  function automatic logic [10:0] outs();
    return {bus.state_out, bus.check_req, bus.pswd_we, bus.clear_entry, bus.err_count, bus.leds};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input string nm, input logic [7:0] s, input logic [10:0] e);
    logic [10:0] want;
    drive(s);
    sb.push_back(e);
    @(posedge clk); #1;
    want = sb.pop_front();
    check(nm, 32'(outs()), 32'(want));
    @(negedge clk);
  endtask

  // counts samples that stay in state st (caller's last sample already counted)
  task automatic measure(input string nm, input logic [1:0] st, input int exp_n,
                         input logic [10:0] exit_exp);
    int cnt = 1;
    bit left = 1'b0;
    for (int i = 0; i < 60 && !left; i++) begin
      drive(IDLE);
      @(posedge clk); #1;
      if (bus.state_out == st) cnt++;
      else left = 1'b1;
      @(negedge clk);
    end
    check({nm, " cycles"}, 32'(cnt), 32'(exp_n));
    check({nm, " exit"}, 32'(left ? outs() : 11'h7ff), 32'(exit_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(8'b1000_0000);
    tbl.push_back(V("reset",        8'b1100_0000, 2'b00, 3'b000, 2'd0, 4'b0001));
    tbl.push_back(V("idle",         8'b0100_0000, 2'b00, 3'b000, 2'd0, 4'b0001));
    tbl.push_back(V("edit",         8'b0110_0000, 2'b01, 3'b001, 2'd0, 4'b0011));
    tbl.push_back(V("digit",        8'b0101_0000, 2'b01, 3'b000, 2'd0, 4'b0011));
    tbl.push_back(V("ok+digit",     8'b0101_1000, 2'b01, 3'b100, 2'd0, 4'b0011));
    tbl.push_back(V("match no cv",  8'b0100_0001, 2'b01, 3'b000, 2'd0, 4'b0011));
    tbl.push_back(V("miss1",        8'b0100_0010, 2'b01, 3'b001, 2'd1, 4'b0011));
    tbl.push_back(V("ok2",          8'b0100_1000, 2'b01, 3'b100, 2'd1, 4'b0011));
    tbl.push_back(V("miss2",        8'b0100_0010, 2'b01, 3'b001, 2'd2, 4'b0011));
    tbl.push_back(V("ok3",          8'b0100_1000, 2'b01, 3'b100, 2'd2, 4'b0011));
    tbl.push_back(V("edit in chk",  8'b0110_0000, 2'b01, 3'b000, 2'd2, 4'b0011));
    tbl.push_back(V("miss3 alarm",  8'b0100_0010, 2'b11, 3'b000, 2'd3, 4'b1111));
    tbl.push_back(V("alarm ok",     8'b0100_1000, 2'b11, 3'b000, 2'd3, 4'b1111));
    tbl.push_back(V("alarm edit",   8'b0110_0000, 2'b11, 3'b000, 2'd3, 4'b0000));
    tbl.push_back(V("alarm cv",     8'b0100_0011, 2'b11, 3'b000, 2'd3, 4'b0000));
    tbl.push_back(V("blink a",      8'b0100_0000, 2'b11, 3'b000, 2'd3, 4'b1111));
    tbl.push_back(V("blink b",      8'b0100_0000, 2'b11, 3'b000, 2'd3, 4'b1111));
    tbl.push_back(V("blink c",      8'b0100_0000, 2'b11, 3'b000, 2'd3, 4'b0000));
    tbl.push_back(V("admin clr",    8'b0100_0100, 2'b00, 3'b001, 2'd0, 4'b0001));
    tbl.push_back(V("aclr waiting", 8'b0100_0100, 2'b00, 3'b000, 2'd0, 4'b0001));
    tbl.push_back(V("adm edit",     8'b0010_0000, 2'b01, 3'b001, 2'd0, 4'b0011));
    tbl.push_back(V("adm ok",       8'b0000_1000, 2'b00, 3'b011, 2'd0, 4'b0001));
    tbl.push_back(V("idle2",        8'b0100_0000, 2'b00, 3'b000, 2'd0, 4'b0001));
    tbl.push_back(V("u edit",       8'b0110_0000, 2'b01, 3'b001, 2'd0, 4'b0011));
    tbl.push_back(V("u ok",         8'b0100_1000, 2'b01, 3'b100, 2'd0, 4'b0011));
    tbl.push_back(V("u match",      8'b0100_0011, 2'b10, 3'b000, 2'd0, 4'b1111));
    tbl.push_back(V("u relock ok",  8'b0100_1000, 2'b00, 3'b001, 2'd0, 4'b0001));
    tbl.push_back(V("r edit",       8'b0110_0000, 2'b01, 3'b001, 2'd0, 4'b0011));
    tbl.push_back(V("r ok1",        8'b0100_1000, 2'b01, 3'b100, 2'd0, 4'b0011));
    tbl.push_back(V("r miss1",      8'b0100_0010, 2'b01, 3'b001, 2'd1, 4'b0011));
    tbl.push_back(V("r ok2",        8'b0100_1000, 2'b01, 3'b100, 2'd1, 4'b0011));
    tbl.push_back(V("r miss2",      8'b0100_0010, 2'b01, 3'b001, 2'd2, 4'b0011));
    tbl.push_back(V("r ok3",        8'b0100_1000, 2'b01, 3'b100, 2'd2, 4'b0011));
    tbl.push_back(V("r miss3",      8'b0100_0010, 2'b11, 3'b000, 2'd3, 4'b1111));
    tbl.push_back(V("rst in alarm", 8'b1100_1100, 2'b00, 3'b000, 2'd0, 4'b0001));
    tbl.push_back(V("after rst",    8'b0100_0000, 2'b00, 3'b000, 2'd0, 4'b0001));

    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i].nm, tbl[i].stim, tbl[i].exp);

    // edit timeout with no activity
    apply("to edit", 8'b0110_0000, E(2'b01, 3'b001, 2'd0, 4'b0011));
    measure("edit timeout", 2'b01, 12, E(2'b00, 3'b001, 2'd0, 4'b0001));

    // CHECK holds without timing out, then unlock auto-relocks
    apply("fz edit", 8'b0110_0000, E(2'b01, 3'b001, 2'd0, 4'b0011));
    apply("fz ok",   8'b0100_1000, E(2'b01, 3'b100, 2'd0, 4'b0011));
    for (int i = 0; i < 20; i++)
      apply("fz wait", IDLE, E(2'b01, 3'b000, 2'd0, 4'b0011));
    apply("fz match", 8'b0100_0011, E(2'b10, 3'b000, 2'd0, 4'b1111));
    measure("unlock timeout", 2'b10, 20, E(2'b00, 3'b001, 2'd0, 4'b0001));

    // digit activity every 10 cycles keeps EDITING alive
    apply("ka edit", 8'b0110_0000, E(2'b01, 3'b001, 2'd0, 4'b0011));
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 9; i++)
        apply("ka idle", IDLE, E(2'b01, 3'b000, 2'd0, 4'b0011));
      apply("ka digit", 8'b0101_0000, E(2'b01, 3'b000, 2'd0, 4'b0011));
    end
    measure("ka timeout", 2'b01, 12, E(2'b00, 3'b001, 2'd0, 4'b0001));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
